// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler: two byte requesters share one 8N1 serializer
// that is paced by an external baud generator gated through bps_en.
module uart_tx_sched #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  input  logic       bps_tick,
  output logic       bps_en,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  // Illegal STOP_BITS values fall back to a single stop bit.
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   shift, shift_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic                stop_cnt, stop_cnt_nxt;
  logic                last, last_nxt;
  logic                txd_nxt, bps_en_nxt, busy_nxt, ack0_nxt, ack1_nxt;

  logic any_req_c;
  logic win_c;
  logic grant_c;
  logic stop_done_c;

  // Winner: the only requester, or the one not served last time on contention.
  assign any_req_c   = req0 | req1;
  assign win_c       = (req0 & req1) ? ~last : req1;
  assign stop_done_c = (stop_cnt == STOP_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      last     <= 1'b1;
      txd      <= 1'b1;
      bps_en   <= 1'b0;
      busy     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift    <= shift_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      last     <= last_nxt;
      txd      <= txd_nxt;
      bps_en   <= bps_en_nxt;
      busy     <= busy_nxt;
      ack0     <= ack0_nxt;
      ack1     <= ack1_nxt;
    end
  end

  // Next-state logic; grant_c marks the cycles where a new byte is taken.
  always_comb begin
    state_nxt = state;
    grant_c   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req_c) begin
          state_nxt = ALIGN;
          grant_c   = 1'b1;
        end
      end
      ALIGN: if (bps_tick) state_nxt = START;
      START: if (bps_tick) state_nxt = DATA;
      DATA:  if (bps_tick && (bit_cnt == CNT_W'(7))) state_nxt = STOP;
      STOP: begin
        if (bps_tick && stop_done_c) begin
          if (any_req_c) begin
            state_nxt = START;
            grant_c   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    shift_nxt    = shift;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    last_nxt     = last;
    txd_nxt      = txd;
    bps_en_nxt   = bps_en;
    ack0_nxt     = 1'b0;
    ack1_nxt     = 1'b0;
    busy_nxt     = (state_nxt != IDLE);

    if (grant_c) begin
      shift_nxt = win_c ? data1 : data0;
      ack0_nxt  = ~win_c;
      ack1_nxt  = win_c;
      last_nxt  = win_c;
    end

    case (state)
      IDLE: begin
        if (any_req_c) begin
          bps_en_nxt = 1'b1;
          txd_nxt    = 1'b1;
        end
      end
      ALIGN: if (bps_tick) txd_nxt = 1'b0;
      START: begin
        if (bps_tick) begin
          txd_nxt     = shift[0];
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        // shift[0] always holds the bit currently on the wire.
        if (bps_tick) begin
          if (bit_cnt != CNT_W'(7)) begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            shift_nxt   = {1'b0, shift[DATA_W-1:1]};
            txd_nxt     = shift[1];
          end else begin
            txd_nxt      = 1'b1;
            stop_cnt_nxt = 1'b0;
          end
        end
      end
      STOP: begin
        if (bps_tick) begin
          stop_cnt_nxt = stop_cnt + 1'b1;
          if (stop_done_c) begin
            if (any_req_c) txd_nxt = 1'b0;
            else           bps_en_nxt = 1'b0;
          end
        end
      end
      default: begin
        txd_nxt    = 1'b1;
        bps_en_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares a single 8N1 UART serializer between two byte requesters. It gates the baud-tick generator through `bps_en`, consumes its one-cycle `bps_tick` pulses as bit boundaries, arbitrates round-robin between requesters, and drives the serial `txd` line. It sits between the SoC-side byte sources (e.g. debug console and status streamer) and the UART pin, next to the baud generator.

## Interface
- `STOP_BITS`, default 1: number of stop bits, legal values 1 or 2.
- `clk`  in  1: system clock; all logic on rising edge.
- `RST`  in  1: reset, asynchronous, active-high.
- `req0`  in  1: requester 0 holds a byte for transmission.
- `data0`  in  8: requester 0 byte; must be stable while `req0` is high.
- `ack0`  out  1: one-cycle pulse when the `data0` byte is latched.
- `req1`  in  1: requester 1 holds a byte for transmission.
- `data1`  in  8: requester 1 byte; must be stable while `req1` is high.
- `ack1`  out  1: one-cycle pulse when the `data1` byte is latched.
- `bps_tick`  in  1: one-cycle baud pulse from the baud generator. Its period is T clk cycles once `bps_en` is high.
- `bps_en`  out  1: enables the baud generator; low keeps the generator counter cleared.
- `txd`  out  1: serial output, idle high, LSB first.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, ALIGN, START, DATA, STOP. All outputs are registered.
- Reset values: state IDLE, `txd`=1, `bps_en`=0, `busy`=0, `ack0`=`ack1`=0, bit counter 0, last-served pointer=1 (requester 0 wins the first contention).
- IDLE: `bps_tick` is ignored. If any req is high, perform a grant, then go to ALIGN. Set `bps_en`=1 and keep `txd`=1.
- Grant:
  - If only one req is high, that requester wins.
  - If both are high, the requester not equal to the last-served pointer wins.
  - Latch the winner's data into the shift register, pulse its ack for exactly one cycle, and update the pointer to the winner.
- ALIGN: wait for the first `bps_tick`, which absorbs the generator's half-period first tick. On the tick, set `txd`=0 and go to START.
- START: on `bps_tick`, set `txd`=shift[0] and go to DATA with bit counter=0.
- DATA: on each `bps_tick`:
  - If bit counter < 7: increment the counter and drive the next bit.
  - If bit counter = 7: set `txd`=1 and go to STOP with stop counter=0.
- STOP: on each `bps_tick`, increment the stop counter. On the tick that completes `STOP_BITS` stop bits:
  - If any req is high: perform a grant, set `txd`=0, and go to START. `bps_en` stays 1 and no ALIGN is needed (back-to-back).
  - Otherwise: go to IDLE with `bps_en`=0.
- A req that drops before grant is simply not served. A req held high after its ack is a new byte request.
- `STOP_BITS` values other than 1 or 2 are treated as 1.

## Timing
- Grant happens in the cycle after req is sampled high in IDLE. The ack pulse, `bps_en`=1 and `busy`=1 all appear in that same cycle.
- `txd` changes on the clk edge after the cycle in which `bps_tick` is high. Each bit therefore lasts exactly T clk cycles.
- Frame on the wire: start bit, 8 data bits LSB first, then `STOP_BITS` stop bits = (9+`STOP_BITS`)·T cycles.
- Back-to-back: the next start bit begins T cycles after the last stop bit began, with no idle gap. The ack pulses in the same cycle `txd` falls.
- Reset asserted mid-frame immediately forces all reset values, so `txd` returns high asynchronously. The pointer returns to 1.
- `bps_tick` is not edge-detected; a pulse longer than one cycle is a protocol violation.

## Test plan
- Bench setup: baud generator with T=8 in all scenarios.
- Single byte: `req0`=1, `data0`=0xA5, dropped after ack.
  - `ack0` pulses once.
  - `txd` sequence is 0,1,0,1,0,0,1,0,1,1, each level 8 cycles.
  - `bps_en` falls at the end of the stop bit; `busy`=0.
- Contention from reset: `req0` and `req1` rise together with 0x11 and 0x22 and are held until acked.
  - Byte 0x11 is sent first, then 0x22 back-to-back with no idle gap.
  - `ack1` pulses in the cycle `txd` falls for the second frame.
- Round-robin fairness: both reqs held permanently (data 0x0F and 0xF0).
  - Frames alternate 0x0F, 0xF0, 0x0F, 0xF0.
  - Each ack pulses every 20·T cycles.
- `STOP_BITS`=2 with byte 0xFF: `txd` is low for 8 cycles, then high for 80 cycles before `bps_en` drops.
- Reset mid-DATA (after bit 3 of 0x00):
  - `txd`=1, `bps_en`=0 and `busy`=0 immediately.
  - After release, a pending `req1` is served before `req0` only if `req0` is low.
- Spurious tick: `bps_tick` pulsed in IDLE with no req → no state change, `txd` stays 1.
